// File: rtl/id_branch_resolve_unit_pkg.sv
// ---------------------------------------------------------------------------
// id_branch_resolve_unit_pkg
// Shared definitions for the ID-stage branch resolution logic:
//   - fwd_sel_e : forward-mux select codes. These match the case labels of
//                 the comparator-operand muxes in the datapath.
//   - state_e   : branch stall FSM state codes.
//   - helpers   : dependence test and forward-source selection.
// ---------------------------------------------------------------------------
package id_branch_resolve_unit_pkg;

    typedef enum logic [1:0] {
        FWD_CUR = 2'b00,   // register file value
        FWD_WB  = 2'b01,   // MEM/WB result
        FWD_MEM = 2'b10    // EX/MEM result
    } fwd_sel_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    // $0 is hardwired to zero. It never forwards and never stalls.
    function automatic logic reg_depends(input logic       reg_write,
                                         input logic [4:0] rd,
                                         input logic [4:0] r);
        return reg_write && (rd == r) && (r != 5'd0);
    endfunction

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    function automatic fwd_sel_e fwd_select(input logic [4:0] r,
                                            input logic       mem_reg_write,
                                            input logic [4:0] mem_rd,
                                            input logic       wb_reg_write,
                                            input logic [4:0] wb_rd);
        if (reg_depends(mem_reg_write, mem_rd, r)) return FWD_MEM;
        if (reg_depends(wb_reg_write, wb_rd, r))   return FWD_WB;
        return FWD_CUR;
    endfunction

endpackage

// File: rtl/id_branch_resolve_unit_branch_hazard_detect.sv
// ---------------------------------------------------------------------------
// branch_hazard_detect
// Combinational forwarding and stall-need logic for an ID-stage branch.
// Ports:
//   i_is_branch              ID instruction is beq or bne
//   i_rs, i_rt               ID source registers
//   i_ex_*  / i_mem_* / i_wb_* pipeline-register write controls
//   o_fwd_a_sel, o_fwd_b_sel forward-mux selects for rs / rt
//   o_need                   stall cycles still required (0..2)
// ---------------------------------------------------------------------------
module branch_hazard_detect
    import id_branch_resolve_unit_pkg::*;
(
    input  logic       i_is_branch,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_ex_reg_write,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    input  logic       i_mem_reg_write,
    input  logic       i_mem_mem_read,
    input  logic [4:0] i_mem_rd,
    input  logic       i_wb_reg_write,
    input  logic [4:0] i_wb_rd,
    output fwd_sel_e   o_fwd_a_sel,
    output fwd_sel_e   o_fwd_b_sel,
    output logic [1:0] o_need
);

    logic [1:0] w_need_a;
    logic [1:0] w_need_b;

    // A load in EX needs two cycles to reach MEM/WB. An ALU op in EX, or a
    // load in MEM, needs one cycle to reach a forwardable stage.
    function automatic logic [1:0] operand_need(input logic [4:0] r);
        if (reg_depends(i_ex_reg_write, i_ex_rd, r) && i_ex_mem_read) return 2'd2;
        if (reg_depends(i_ex_reg_write, i_ex_rd, r))                  return 2'd1;
        if (reg_depends(i_mem_reg_write, i_mem_rd, r) && i_mem_mem_read) return 2'd1;
        return 2'd0;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave a
        // value unassigned and infer a latch.
        o_fwd_a_sel = fwd_select(i_rs, i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);
        o_fwd_b_sel = fwd_select(i_rt, i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);
        w_need_a    = 2'd0;
        w_need_b    = 2'd0;
        if (i_is_branch) begin
            w_need_a = operand_need(i_rs);
            w_need_b = operand_need(i_rt);
        end
        o_need = (w_need_a > w_need_b) ? w_need_a : w_need_b;
    end

endmodule

// File: rtl/id_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// id_branch_resolve_unit
// ID-stage branch control for a 5-stage MIPS pipeline that resolves
// branches in ID.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_branch_eq/ne, id_rs/rt          ID branch decode and sources
//   id_pc_plus4, id_imm16              target computation inputs
//   ex_*/mem_*/wb_*                    downstream write controls
//   cmp_a, cmp_b                       forwarded comparator operands
//   fwd_a_sel, fwd_b_sel               comparator forward-mux selects
//   stall                              hold PC and IF/ID, bubble ID/EX
//   pc_src, flush_if_id                redirect fetch on a taken branch
//   branch_target                      PC+4 + (sext(imm) << 2)
//   taken_cnt                          taken branches since reset (wraps)
// ---------------------------------------------------------------------------
module id_branch_resolve_unit
    import id_branch_resolve_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_branch_eq,
    input  logic             id_branch_ne,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [31:0]      id_pc_plus4,
    input  logic [15:0]      id_imm16,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      cmp_a,
    input  logic [31:0]      cmp_b,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             pc_src,
    output logic             flush_if_id,
    output logic [31:0]      branch_target,
    output logic [CNT_W-1:0] taken_cnt
);

    state_e           r_state;
    logic [1:0]       r_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    fwd_sel_e w_fwd_a;
    fwd_sel_e w_fwd_b;
    logic [1:0] w_need;
    logic w_is_branch;
    logic w_stall;
    logic w_taken;

    assign w_is_branch = id_branch_eq | id_branch_ne;

    branch_hazard_detect u_hazard (
        .i_is_branch    (w_is_branch),
        .i_rs           (id_rs),
        .i_rt           (id_rt),
        .i_ex_reg_write (ex_reg_write),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_rd        (ex_rd),
        .i_mem_reg_write(mem_reg_write),
        .i_mem_mem_read (mem_mem_read),
        .i_mem_rd       (mem_rd),
        .i_wb_reg_write (wb_reg_write),
        .i_wb_rd        (wb_rd),
        .o_fwd_a_sel    (w_fwd_a),
        .o_fwd_b_sel    (w_fwd_b),
        .o_need         (w_need)
    );

    // WAIT stalls unconditionally; IDLE stalls as soon as a hazard is seen.
    assign w_stall = (r_state == S_WAIT) || (w_need != 2'd0);

    // If both decode bits are set, the instruction is treated as beq.
    always_comb begin
        w_taken = 1'b0;
        if (!w_stall) begin
            if (id_branch_eq)      w_taken = (cmp_a == cmp_b);
            else if (id_branch_ne) w_taken = (cmp_a != cmp_b);
        end
    end

    // Control outputs are forced idle while reset is held, even though the
    // hazard logic is purely combinational.
    assign stall         = rst_n & w_stall;
    assign pc_src        = rst_n & w_taken;
    assign flush_if_id   = rst_n & w_taken;
    assign fwd_a_sel     = rst_n ? w_fwd_a : FWD_CUR;
    assign fwd_b_sel     = rst_n ? w_fwd_b : FWD_CUR;
    assign branch_target = id_pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
    assign taken_cnt     = r_taken_cnt;

    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_taken_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_need != 2'd0) begin
                        // This cycle is the first stall. Count the rest.
                        r_cnt <= w_need - 2'd1;
                        if (w_need > 2'd1) r_state <= S_WAIT;
                    end else if (w_taken) begin
                        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_branch_resolve_unit.sv
module tb_id_branch_resolve_unit;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             id_branch_eq;
    logic             id_branch_ne;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [31:0]      id_pc_plus4;
    logic [15:0]      id_imm16;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic [4:0]       mem_rd;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [31:0]      cmp_a;
    logic [31:0]      cmp_b;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic             pc_src;
    logic             flush_if_id;
    logic [31:0]      branch_target;
    logic [CNT_W-1:0] taken_cnt;

    int checks;
    int errors;

    id_branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_branch_eq (id_branch_eq),
        .id_branch_ne (id_branch_ne),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_pc_plus4  (id_pc_plus4),
        .id_imm16     (id_imm16),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read (mem_mem_read),
        .mem_rd       (mem_rd),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .cmp_a        (cmp_a),
        .cmp_b        (cmp_b),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .pc_src       (pc_src),
        .flush_if_id  (flush_if_id),
        .branch_target(branch_target),
        .taken_cnt    (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_branch_eq  = 1'b0;
        id_branch_ne  = 1'b0;
        id_rs         = 5'd0;
        id_rt         = 5'd0;
        id_pc_plus4   = 32'd0;
        id_imm16      = 16'd0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_rd         = 5'd0;
        mem_reg_write = 1'b0;
        mem_mem_read  = 1'b0;
        mem_rd        = 5'd0;
        wb_reg_write  = 1'b0;
        wb_rd         = 5'd0;
        cmp_a         = 32'd0;
        cmp_b         = 32'd0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Control vector: {stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel}
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        id_branch_eq = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
        cmp_a = 32'd5; cmp_b = 32'd5;
        // A pending hazard and forward source that reset must mask.
        ex_reg_write = 1'b1; ex_rd = 5'd1;
        mem_reg_write = 1'b1; mem_rd = 5'd2;
        #2;
        checks++;
        if ({stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel});
        end
        step();
        checks++;
        if (taken_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", taken_cnt);
        end
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({stall, pc_src, flush_if_id} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle got %b exp 000", {stall, pc_src, flush_if_id});
        end
    endtask

    task automatic test_alu_hazard();
        // add $3 in EX, beq $3,$4 in ID
        id_branch_eq = 1'b1; id_rs = 5'd3; id_rt = 5'd4;
        ex_reg_write = 1'b1; ex_rd = 5'd3;
        #1;
        checks++;
        if ({stall, pc_src} !== 2'b10) begin
            errors++;
            $display("FAIL alu_stall1 got %b exp 10", {stall, pc_src});
        end
        step();
        // add moves to EX/MEM, bubble in EX
        ex_reg_write = 1'b0; ex_rd = 5'd0;
        mem_reg_write = 1'b1; mem_rd = 5'd3;
        cmp_a = 32'd7; cmp_b = 32'd7;
        #1;
        checks++;
        if ({stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel} !== 7'b0_1_1_10_00) begin
            errors++;
            $display("FAIL alu_resolve got %b exp 0111000",
                     {stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel});
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (taken_cnt !== 2'd1) begin
            errors++;
            $display("FAIL alu_taken_cnt got %0d exp 1", taken_cnt);
        end
    endtask

    task automatic test_load_hazard();
        // lw $5 in EX, bne $6,$5 in ID
        id_branch_ne = 1'b1; id_rs = 5'd6; id_rt = 5'd5;
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_stall1 got %b exp 1", stall);
        end
        step();
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd5;
        #1;
        checks++;
        if ({stall, pc_src} !== 2'b10) begin
            errors++;
            $display("FAIL load_stall2 got %b exp 10", {stall, pc_src});
        end
        step();
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = 5'd0;
        wb_reg_write = 1'b1; wb_rd = 5'd5;
        cmp_a = 32'd1; cmp_b = 32'd1;
        #1;
        checks++;
        if ({stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel} !== 7'b0_0_0_00_01) begin
            errors++;
            $display("FAIL load_resolve got %b exp 0000001",
                     {stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel});
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (taken_cnt !== 2'd1) begin
            errors++;
            $display("FAIL load_taken_cnt got %0d exp 1", taken_cnt);
        end
    endtask

    task automatic test_reg_zero();
        id_branch_eq = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0;
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd0;
        wb_reg_write = 1'b1; wb_rd = 5'd0;
        #1;
        checks++;
        if ({stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel} !== 7'b0_1_1_00_00) begin
            errors++;
            $display("FAIL zero_reg got %b exp 0110000",
                     {stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel});
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (taken_cnt !== 2'd2) begin
            errors++;
            $display("FAIL zero_taken_cnt got %0d exp 2", taken_cnt);
        end
    endtask

    task automatic test_target();
        logic [31:0] pcs [3];
        logic [15:0] imms [3];
        logic [31:0] exps [3];
        pcs[0] = 32'h0000_0010; imms[0] = 16'hFFFC; exps[0] = 32'h0000_0000;
        pcs[1] = 32'h0000_0100; imms[1] = 16'h0003; exps[1] = 32'h0000_010C;
        pcs[2] = 32'h0000_1000; imms[2] = 16'h7FFF; exps[2] = 32'h0002_0FFC;
        for (int i = 0; i < 3; i++) begin
            id_pc_plus4 = pcs[i];
            id_imm16    = imms[i];
            #1;
            checks++;
            if (branch_target !== exps[i]) begin
                errors++;
                $display("FAIL target_%0d got %h exp %h", i, branch_target, exps[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_non_branch_and_both();
        // Non-branch: EX hazard must not stall; EX/MEM beats MEM/WB for rs.
        id_rs = 5'd8; id_rt = 5'd9;
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8;
        mem_reg_write = 1'b1; mem_rd = 5'd8;
        wb_reg_write = 1'b1; wb_rd = 5'd8;
        cmp_a = 32'd3; cmp_b = 32'd3;
        #1;
        checks++;
        if ({stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel} !== 7'b0_0_0_10_00) begin
            errors++;
            $display("FAIL non_branch got %b exp 0001000",
                     {stall, pc_src, flush_if_id, fwd_a_sel, fwd_b_sel});
        end
        clear_inputs();
        // beq and bne both high acts as beq: unequal operands -> not taken.
        id_branch_eq = 1'b1; id_branch_ne = 1'b1;
        id_rs = 5'd1; id_rt = 5'd2;
        cmp_a = 32'd4; cmp_b = 32'd9;
        #1;
        checks++;
        if ({stall, pc_src} !== 2'b00) begin
            errors++;
            $display("FAIL both_neq got %b exp 00", {stall, pc_src});
        end
        cmp_b = 32'd4;
        #1;
        checks++;
        if ({stall, pc_src} !== 2'b01) begin
            errors++;
            $display("FAIL both_eq got %b exp 01", {stall, pc_src});
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (taken_cnt !== 2'd3) begin
            errors++;
            $display("FAIL both_taken_cnt got %0d exp 3", taken_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        id_branch_ne = 1'b1; id_rs = 5'd6; id_rt = 5'd5;
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
        step();
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd5;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall got %b exp 1", stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, pc_src, taken_cnt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_wait got %b exp 0000", {stall, pc_src, taken_cnt});
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL after_wait_reset got %b exp 0", stall);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [CNT_W-1:0] exp_cnt;
        exp_cnt = '0;
        id_rs = 5'd1; id_rt = 5'd2;
        // Five taken branches back to back, alternating beq/bne.
        for (int i = 0; i < 5; i++) begin
            id_branch_eq = (i % 2 == 0);
            id_branch_ne = (i % 2 != 0);
            cmp_a = 32'd10;
            cmp_b = (i % 2 == 0) ? 32'd10 : 32'd11;
            #1;
            checks++;
            if ({stall, pc_src} !== 2'b01) begin
                errors++;
                $display("FAIL b2b_taken_%0d got %b exp 01", i, {stall, pc_src});
            end
            step();
            exp_cnt = exp_cnt + 2'd1;
            checks++;
            if (taken_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL b2b_cnt_%0d got %0d exp %0d", i, taken_cnt, exp_cnt);
            end
        end
        clear_inputs();
        #1;
        checks++;
        if (taken_cnt !== 2'd1) begin
            errors++;
            $display("FAIL wrap_cnt got %0d exp 1", taken_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_hazard();
        test_load_hazard();
        test_reg_zero();
        test_target();
        test_non_branch_and_both();
        test_reset_mid_wait();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
